// File: rtl/decode_stage_if.sv
// Handshake bundles for decode_stage: fetch->decode (decode_in_if) and
// decode->execute (decode_out_if). The master drives valid and payload, the slave drives ready.
interface decode_in_if #(
  parameter int P_PC_W = 32
);
  logic              valid;
  logic              ready;
  logic [31:0]       inst;
  logic [P_PC_W-1:0] pc;

  modport master (output valid, output inst, output pc, input ready);
  modport slave  (input valid, input inst, input pc, output ready);
endinterface

interface decode_out_if #(
  parameter int P_PC_W = 32
);
  logic              valid;
  logic              ready;
  logic [17:0]       ctrl;
  logic [31:0]       imm;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [P_PC_W-1:0] pc;
  logic              illegal;

  modport master (output valid, output ctrl, output imm, output rd, output rs1,
                  output rs2, output pc, output illegal, input ready);
  modport slave  (input valid, input ctrl, input imm, input rd, input rs1,
                  input rs2, input pc, input illegal, output ready);
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a valid/ready skid buffer and synchronous flush.
// Define DECODE_MEXT_EN to accept the M-extension R-type encodings (funct7=0000001).
module decode_stage #(
  parameter int P_PC_W = 32,
  parameter int P_SKID = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Flush,
  decode_in_if.slave   in_if,
  decode_out_if.master out_if
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [17:0]       ctrl;
    logic [31:0]       imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [P_PC_W-1:0] pc;
    logic              illegal;
  } entry_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;

  function automatic entry_t decode(input logic [31:0] inst, input logic [P_PC_W-1:0] pc);
    entry_t     e;
    logic       reg_we;
    logic [1:0] wb_src;
    logic       dbus_re;
    logic       dbus_we;
    logic       is_branch;
    logic       is_jump;
    logic [4:0] alu_op;
    logic [1:0] a_sel;
    logic       b_sel;
    logic       ill;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm;

    f3        = inst[14:12];
    f7        = inst[31:25];
    reg_we    = 1'b0;
    wb_src    = 2'b00;
    dbus_re   = 1'b0;
    dbus_we   = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    alu_op    = ALU_ADD;
    a_sel     = 2'b00;
    b_sel     = 1'b0;
    ill       = 1'b0;
    imm       = 32'd0;

    case (inst[6:0])
      OPC_OP: begin
        reg_we = 1'b1;
        if (f7 == 7'b0000000) begin
          alu_op = {2'b00, f3};
        end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          alu_op = {2'b01, f3};
`ifdef DECODE_MEXT_EN
        end else if (f7 == 7'b0000001) begin
          alu_op = {2'b10, f3};
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        reg_we = 1'b1;
        b_sel  = 1'b1;
        imm    = {{20{inst[31]}}, inst[31:20]};
        if (f3 == 3'b101) begin
          alu_op = {1'b0, inst[30], f3};
          ill    = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
        end else if (f3 == 3'b001) begin
          alu_op = {2'b00, f3};
          ill    = (f7 != 7'b0000000);
        end else begin
          alu_op = {2'b00, f3};
        end
      end
      OPC_LOAD: begin
        reg_we  = 1'b1;
        wb_src  = 2'b01;
        dbus_re = 1'b1;
        b_sel   = 1'b1;
        imm     = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        dbus_we = 1'b1;
        b_sel   = 1'b1;
        imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
        imm       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        reg_we  = 1'b1;
        is_jump = 1'b1;
        wb_src  = 2'b10;
        a_sel   = 2'b01;
        b_sel   = 1'b1;
        imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        reg_we  = 1'b1;
        is_jump = 1'b1;
        wb_src  = 2'b10;
        b_sel   = 1'b1;
        imm     = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_LUI: begin
        reg_we = 1'b1;
        a_sel  = 2'b10;
        b_sel  = 1'b1;
        imm    = {inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        reg_we = 1'b1;
        a_sel  = 2'b01;
        b_sel  = 1'b1;
        imm    = {inst[31:12], 12'd0};
      end
      default: begin
        ill = 1'b1;
      end
    endcase

    if (inst[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      ill = ill;
    end

    // Writes to x0 are dropped here so execute never needs to check rd.
    if (inst[11:7] == 5'd0) begin
      reg_we = 1'b0;
    end else begin
      reg_we = reg_we;
    end

    e.ctrl    = ill ? 18'd0 : {reg_we, wb_src, f3, dbus_re, dbus_we, is_branch,
                               is_jump, alu_op, a_sel, b_sel};
    e.imm     = imm;
    e.rd      = inst[11:7];
    e.rs1     = inst[19:15];
    e.rs2     = inst[24:20];
    e.pc      = pc;
    e.illegal = ill;
    return e;
  endfunction

  occ_e   state_q, state_d;
  logic   valid_q, valid_d;
  logic   ready_q, ready_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t dec_s;
  logic   in_ready_s;
  logic   push_s;
  logic   pop_s;

  generate
    if (P_SKID != 0) begin : g_skid
      assign in_ready_s = ready_q;
    end else begin : g_noskid
      assign in_ready_s = !valid_q | out_if.ready;
    end
  endgenerate

  assign dec_s  = decode(in_if.inst, in_if.pc);
  assign push_s = in_if.valid & in_ready_s;
  assign pop_s  = valid_q & out_if.ready;

  // Occupancy next-state and buffer data movement; flush overrides everything.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (i_Flush) begin
      state_d = ST_EMPTY;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            head_d  = dec_s;
            valid_d = 1'b1;
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_d = dec_s;
          end else if (push_s) begin
            if (P_SKID != 0) begin
              skid_d  = dec_s;
              state_d = ST_TWO;
            end else begin
              state_d = ST_ONE;
            end
          end else if (pop_s) begin
            valid_d = 1'b0;
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_EMPTY;
        end
      endcase
    end
    ready_d = (state_d != ST_TWO);
  end

  // State and buffer registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign in_if.ready    = in_ready_s;
  assign out_if.valid   = valid_q;
  assign out_if.ctrl    = head_q.ctrl;
  assign out_if.imm     = head_q.imm;
  assign out_if.rd      = head_q.rd;
  assign out_if.rs1     = head_q.rs1;
  assign out_if.rs2     = head_q.rs2;
  assign out_if.pc      = head_q.pc;
  assign out_if.illegal = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, backpressure, flush, reset.
module tb_decode_stage;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  decode_in_if  #(.P_PC_W(32)) in_if ();
  decode_out_if #(.P_PC_W(32)) out_if ();

  decode_stage #(.P_PC_W(32), .P_SKID(1)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Flush (flush),
    .in_if   (in_if),
    .out_if  (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk_ctrl(input logic regwe, input logic [1:0] wb,
                                          input logic [2:0] f3, input logic re,
                                          input logic we, input logic br, input logic jmp,
                                          input logic [4:0] alu, input logic [1:0] asel,
                                          input logic bsel);
    return {regwe, wb, f3, re, we, br, jmp, alu, asel, bsel};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_if.valid = 1'b1;
    in_if.inst  = inst;
    in_if.pc    = pc;
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input logic [17:0] ctrl, input logic [31:0] imm,
                         input logic [4:0] rd, input logic ill, input logic [31:0] pc);
    chk({tag, ".valid"}, 64'(out_if.valid), 64'd1);
    chk({tag, ".ctrl"}, 64'(out_if.ctrl), 64'(ctrl));
    chk({tag, ".imm"}, 64'(out_if.imm), 64'(imm));
    chk({tag, ".rd"}, 64'(out_if.rd), 64'(rd));
    chk({tag, ".illegal"}, 64'(out_if.illegal), 64'(ill));
    chk({tag, ".pc"}, 64'(out_if.pc), 64'(pc));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    in_if.valid   = 1'b0;
    in_if.inst    = 32'd0;
    in_if.pc      = 32'd0;
    out_if.ready  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(out_if.valid), 64'd0);
    chk("rst.ready", 64'(in_if.ready), 64'd1);
    chk("rst.ctrl", 64'(out_if.ctrl), 64'd0);
    chk("rst.imm", 64'(out_if.imm), 64'd0);
    chk("rst.rd", 64'(out_if.rd), 64'd0);
    chk("rst.pc", 64'(out_if.pc), 64'd0);
    chk("rst.illegal", 64'(out_if.illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,5
    send(32'h00500093, 32'h00000100);
    chk_dec("addi", mk_ctrl(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 1'b1),
            32'd5, 5'd1, 1'b0, 32'h00000100);
    chk("addi.rs1", 64'(out_if.rs1), 64'd0);

    // lui x2,0x12345
    send(32'h12345137, 32'h00000104);
    chk_dec("lui", mk_ctrl(1'b1, 2'b00, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b10, 1'b1),
            32'h12345000, 5'd2, 1'b0, 32'h00000104);

    // nop: rd=0 kills RegWe
    send(32'h00000013, 32'h00000108);
    chk_dec("nop", 18'h00001, 32'd0, 5'd0, 1'b0, 32'h00000108);

    // all-zero word is illegal
    send(32'h00000000, 32'h0000010C);
    chk_dec("zero", 18'd0, 32'd0, 5'd0, 1'b1, 32'h0000010C);

    // sub x4,x1,x2
    send(32'h40208233, 32'h00000110);
    chk_dec("sub", mk_ctrl(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000, 2'b00, 1'b0),
            32'd0, 5'd4, 1'b0, 32'h00000110);
    chk("sub.rs1", 64'(out_if.rs1), 64'd1);
    chk("sub.rs2", 64'(out_if.rs2), 64'd2);

    // srai x5,x1,3
    send(32'h4030D293, 32'h00000114);
    chk_dec("srai", mk_ctrl(1'b1, 2'b00, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01101, 2'b00, 1'b1),
            32'h00000403, 5'd5, 1'b0, 32'h00000114);

    // slli with funct7=0100000 is illegal
    send(32'h40109293, 32'h00000118);
    chk("slli_bad.illegal", 64'(out_if.illegal), 64'd1);
    chk("slli_bad.ctrl", 64'(out_if.ctrl), 64'd0);

    // sw x2,-4(x1)
    send(32'hFE20AE23, 32'h0000011C);
    chk_dec("sw", mk_ctrl(1'b0, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 2'b00, 1'b1),
            32'hFFFFFFFC, 5'd28, 1'b0, 32'h0000011C);

    // beq x1,x2,-8
    send(32'hFE208CE3, 32'h00000120);
    chk_dec("beq", mk_ctrl(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01000, 2'b00, 1'b0),
            32'hFFFFFFF8, 5'd25, 1'b0, 32'h00000120);

    // jal x1,+16
    send(32'h010000EF, 32'h00000124);
    chk_dec("jal", mk_ctrl(1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 2'b01, 1'b1),
            32'd16, 5'd1, 1'b0, 32'h00000124);

    // mul x3,x1,x2
    send(32'h022081B3, 32'h00000128);
`ifdef DECODE_MEXT_EN
    chk_dec("mul", mk_ctrl(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000, 2'b00, 1'b0),
            32'd0, 5'd3, 1'b0, 32'h00000128);
`else
    chk_dec("mul", 18'd0, 32'd0, 5'd3, 1'b1, 32'h00000128);
`endif
    @(posedge clk);
    #1;
    chk("drain.valid", 64'(out_if.valid), 64'd0);

    // Backpressure: three back-to-back inputs, execute stalled
    out_if.ready = 1'b0;
    in_if.valid  = 1'b1;
    in_if.inst   = 32'h00500093;
    in_if.pc     = 32'h00000200;
    @(posedge clk);
    #1;
    chk("bp1.pc", 64'(out_if.pc), 64'h200);
    chk("bp1.ready", 64'(in_if.ready), 64'd1);
    in_if.inst = 32'h12345137;
    in_if.pc   = 32'h00000204;
    @(posedge clk);
    #1;
    chk("bp2.ready", 64'(in_if.ready), 64'd0);
    chk("bp2.pc", 64'(out_if.pc), 64'h200);
    in_if.inst = 32'h00000013;
    in_if.pc   = 32'h00000208;
    @(posedge clk);
    #1;
    chk("bp3.ready", 64'(in_if.ready), 64'd0);
    chk("bp3.pc_hold", 64'(out_if.pc), 64'h200);
    chk("bp3.imm_hold", 64'(out_if.imm), 64'd5);
    out_if.ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp4.pc", 64'(out_if.pc), 64'h204);
    chk("bp4.imm", 64'(out_if.imm), 64'h12345000);
    chk("bp4.ready", 64'(in_if.ready), 64'd1);
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    chk("bp5.pc", 64'(out_if.pc), 64'h208);
    chk("bp5.valid", 64'(out_if.valid), 64'd1);
    @(posedge clk);
    #1;
    chk("bp6.valid", 64'(out_if.valid), 64'd0);

    // Flush with two buffered entries and a concurrent input
    out_if.ready = 1'b0;
    send(32'h00500093, 32'h00000300);
    send(32'h12345137, 32'h00000304);
    chk("fl0.ready", 64'(in_if.ready), 64'd0);
    flush       = 1'b1;
    in_if.valid = 1'b1;
    in_if.inst  = 32'h00000013;
    in_if.pc    = 32'h00000308;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    in_if.valid = 1'b0;
    chk("fl1.valid", 64'(out_if.valid), 64'd0);
    chk("fl1.ready", 64'(in_if.ready), 64'd1);
    out_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("fl2.valid", 64'(out_if.valid), 64'd0);
    send(32'h00000013, 32'h00000400);
    chk("fl3.pc", 64'(out_if.pc), 64'h400);
    chk("fl3.valid", 64'(out_if.valid), 64'd1);

    // Asynchronous reset mid-transfer
    out_if.ready = 1'b0;
    send(32'h00500093, 32'h00000500);
    send(32'h12345137, 32'h00000504);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(out_if.valid), 64'd0);
    chk("ar.ready", 64'(in_if.ready), 64'd1);
    chk("ar.ctrl", 64'(out_if.ctrl), 64'd0);
    chk("ar.pc", 64'(out_if.pc), 64'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    out_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ar2.valid", 64'(out_if.valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
